// File: rtl/ibus_stream_port_if.sv
// Bus and stream bundle for ibus_stream_port.
// The slave modport is the view taken by the port itself.
// The master modport is the view taken by the io-bus host and the stream partners.
interface ibus_stream_port_if;
  logic        ibus_ren;
  logic [15:0] ibus_radr;
  logic [15:0] ibus32_rdata;
  logic        ibus_wen;
  logic [15:0] ibus_wadr;
  logic [15:0] ibus32_wdata;
  logic        tx_valid;
  logic        tx_ready;
  logic [15:0] tx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic [15:0] rx_data;

  modport slave (
    input  ibus_ren, ibus_radr, ibus_wen, ibus_wadr, ibus32_wdata,
    input  tx_ready, rx_valid, rx_data,
    output ibus32_rdata, tx_valid, tx_data, rx_ready
  );

  modport master (
    output ibus_ren, ibus_radr, ibus_wen, ibus_wadr, ibus32_wdata,
    output tx_ready, rx_valid, rx_data,
    input  ibus32_rdata, tx_valid, tx_data, rx_ready
  );
endinterface

// File: rtl/ibus_stream_port.sv
// ibus_stream_port: bridges a 256-word io-bus window to a pair of stream FIFOs.
// Offsets 0x00-0xFE of the window alias the FIFO data port, and offset 0xFF is STATUS.
// Reads return data two cycles after the strobe.
// The read data bus is zero in every cycle that carries no response, so it can be OR-combined.
//
// STATUS bit map (read):
//   [15] = 0
//   [14:10] = rx_count
//   [9:5] = tx_count
//   [4] = LPBK
//   [3] = RX_UDF
//   [2] = TX_OVF
//   [1] = rx_empty
//   [0] = tx_full
// Both counts saturate at 31.
// The read bit positions of the flags match the bits used to clear or write them.
//
// Optional feature: define IBUS_STREAM_LOOPBACK_EN to add the LPBK register.
// With LPBK set, the TX head is moved into the RX FIFO and both stream handshakes are parked.
module ibus_stream_port #(
  parameter logic [15:0] BASE_ADR = 16'h0100,
  parameter int          DEPTH    = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               rst_pipe,
  ibus_stream_port_if.slave  bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [15:0]   txMem [DEPTH];
  logic [15:0]   rxMem [DEPTH];
  logic [AW-1:0] txWptr_q, txRptr_q, rxWptr_q, rxRptr_q;
  logic [CW-1:0] txCount_q, rxCount_q, txCount_d, rxCount_d;
  logic          txOvf_q, rxUdf_q, txOvf_d, rxUdf_d;
  logic [15:0]   rsp1_q, rsp2_q, rsp1_d;
  logic          lpbk;

  logic [15:0] rdOff, wrOff;
  logic        rdHit, rdStatus, rdData, wrHit, wrStatus, wrData;
  logic        txEmpty, txFull, rxEmpty, rxFull;
  logic [15:0] txHead, rxHead, rxPushData, statusWord;
  logic        txPush, txPop, rxPush, rxPop, lpbkMove, txValid, rxReady;

  function automatic logic [4:0] sat5(input logic [CW-1:0] c);
    return (32'(c) > 32'd31) ? 5'd31 : 5'(c);
  endfunction

  // Window decode for both strobes; the subtraction never wraps once addr >= BASE_ADR
  always_comb begin
    rdOff    = bus.ibus_radr - BASE_ADR;
    wrOff    = bus.ibus_wadr - BASE_ADR;
    rdHit    = bus.ibus_ren && (bus.ibus_radr >= BASE_ADR) && (rdOff[15:8] == 8'h00);
    wrHit    = bus.ibus_wen && (bus.ibus_wadr >= BASE_ADR) && (wrOff[15:8] == 8'h00);
    rdStatus = rdHit && (rdOff[7:0] == 8'hFF);
    rdData   = rdHit && (rdOff[7:0] != 8'hFF);
    wrStatus = wrHit && (wrOff[7:0] == 8'hFF);
    wrData   = wrHit && (wrOff[7:0] != 8'hFF);
  end

  assign txEmpty = (txCount_q == '0);
  assign txFull  = (txCount_q == FULL_CNT);
  assign rxEmpty = (rxCount_q == '0);
  assign rxFull  = (rxCount_q == FULL_CNT);
  assign txHead  = txEmpty ? 16'h0000 : txMem[txRptr_q];
  assign rxHead  = rxEmpty ? 16'h0000 : rxMem[rxRptr_q];

`ifdef IBUS_STREAM_LOOPBACK_EN
  logic lpbk_q;

  // LPBK is loaded from STATUS bit4 and cleared by either reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lpbk_q <= 1'b0;
    end else if (rst_pipe) begin
      lpbk_q <= 1'b0;
    end else if (wrStatus) begin
      lpbk_q <= bus.ibus32_wdata[4];
    end
  end

  assign lpbk = lpbk_q;
`else
  assign lpbk = 1'b0;
`endif

  // Transfer decisions; a write into a full TX FIFO is dropped rather than stalled
  always_comb begin
    lpbkMove   = lpbk && !txEmpty && !rxFull;
    txValid    = !lpbk && !txEmpty;
    rxReady    = !lpbk && !rxFull;
    txPush     = wrData && !txFull;
    txPop      = (txValid && bus.tx_ready) || lpbkMove;
    rxPush     = (rxReady && bus.rx_valid) || lpbkMove;
    rxPushData = lpbkMove ? txHead : bus.rx_data;
    rxPop      = rdData && !rxEmpty;
  end

  // Next-state for counts, sticky flags (set beats clear) and the first response stage
  always_comb begin
    statusWord = {1'b0, sat5(rxCount_q), sat5(txCount_q), lpbk, rxUdf_q, txOvf_q, rxEmpty, txFull};
    txCount_d  = txCount_q + CW'(txPush) - CW'(txPop);
    rxCount_d  = rxCount_q + CW'(rxPush) - CW'(rxPop);
    txOvf_d    = (txOvf_q && !(wrStatus && bus.ibus32_wdata[2])) || (wrData && txFull);
    rxUdf_d    = (rxUdf_q && !(wrStatus && bus.ibus32_wdata[3])) || (rdData && rxEmpty);
    rsp1_d     = 16'h0000;
    if (rdStatus) begin
      rsp1_d = statusWord;
    end else if (rxPop) begin
      rsp1_d = rxHead;
    end
  end

  // Pointers, counts, flags and the two-stage response pipe; rst_pipe mirrors rst_n
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      txWptr_q  <= '0;
      txRptr_q  <= '0;
      rxWptr_q  <= '0;
      rxRptr_q  <= '0;
      txCount_q <= '0;
      rxCount_q <= '0;
      txOvf_q   <= 1'b0;
      rxUdf_q   <= 1'b0;
      rsp1_q    <= 16'h0000;
      rsp2_q    <= 16'h0000;
    end else if (rst_pipe) begin
      txWptr_q  <= '0;
      txRptr_q  <= '0;
      rxWptr_q  <= '0;
      rxRptr_q  <= '0;
      txCount_q <= '0;
      rxCount_q <= '0;
      txOvf_q   <= 1'b0;
      rxUdf_q   <= 1'b0;
      rsp1_q    <= 16'h0000;
      rsp2_q    <= 16'h0000;
    end else begin
      if (txPush) txWptr_q <= txWptr_q + 1'b1;
      if (txPop)  txRptr_q <= txRptr_q + 1'b1;
      if (rxPush) rxWptr_q <= rxWptr_q + 1'b1;
      if (rxPop)  rxRptr_q <= rxRptr_q + 1'b1;
      txCount_q <= txCount_d;
      rxCount_q <= rxCount_d;
      txOvf_q   <= txOvf_d;
      rxUdf_q   <= rxUdf_d;
      rsp1_q    <= rsp1_d;
      rsp2_q    <= rsp1_q;
    end
  end

  // FIFO storage needs no reset; empty entries are masked by the counts
  always_ff @(posedge clk) begin
    if (txPush) txMem[txWptr_q] <= bus.ibus32_wdata;
    if (rxPush) rxMem[rxWptr_q] <= rxPushData;
  end

  assign bus.ibus32_rdata = rsp2_q;
  assign bus.tx_valid     = txValid;
  assign bus.tx_data      = txValid ? txHead : 16'h0000;
  assign bus.rx_ready     = rxReady;

endmodule

// File: tb/tb_ibus_stream_port.sv
// Self-checking bench for ibus_stream_port.
// A queue-based reference model predicts every output in every cycle.
// Directed scenarios are followed by a randomized phase.
module tb_ibus_stream_port;

  localparam logic [15:0] BASE  = 16'h0100;
  localparam int          DEPTH = 16;

  logic clk = 1'b0;
  logic rst_n;
  logic rst_pipe;

  always #5 clk = ~clk;

  ibus_stream_port_if ifc();

  ibus_stream_port #(.BASE_ADR(BASE), .DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .rst_pipe (rst_pipe),
    .bus      (ifc)
  );

  int testsRun  = 0;
  int failCount = 0;

  logic [15:0] mTx[$];
  logic [15:0] mRx[$];
  logic        mOvf, mUdf, mLpbk;
  logic [15:0] mRsp0, mRsp1;

  logic [15:0] obsRdata, obsTxData;
  logic        obsTxValid;

  task automatic checkOutput(input string tag, input logic [15:0] got, input logic [15:0] exp);
    testsRun++;
    if (got !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [4:0] satCount(input int n);
    return (n > 31) ? 5'd31 : 5'(n);
  endfunction

  function automatic logic [15:0] modelStatus();
    return {1'b0, satCount(mRx.size()), satCount(mTx.size()), mLpbk, mUdf, mOvf,
            (mRx.size() == 0), (mTx.size() == DEPTH)};
  endfunction

  task automatic modelReset();
    mTx.delete();
    mRx.delete();
    mOvf  = 1'b0;
    mUdf  = 1'b0;
    mLpbk = 1'b0;
    mRsp0 = 16'h0000;
    mRsp1 = 16'h0000;
  endtask

  // One clock cycle: drive, check every output against the model, advance the model
  task automatic applyStimulus(input logic ren, input logic [15:0] radr,
                               input logic wen, input logic [15:0] wadr, input logic [15:0] wdata,
                               input logic txReady, input logic rxValid, input logic [15:0] rxData,
                               input logic pipeRst);
    int          ra, wa, base, txN, rxN;
    logic        rdHit, rdSt, rdDat, wrHit, wrSt, wrDat;
    logic        expTxValid, expRxReady, txPop, rxPush, move, setOvf, setUdf;
    logic [15:0] newRsp, moveVal;
    ifc.ibus_ren     = ren;
    ifc.ibus_radr    = radr;
    ifc.ibus_wen     = wen;
    ifc.ibus_wadr    = wadr;
    ifc.ibus32_wdata = wdata;
    ifc.tx_ready     = txReady;
    ifc.rx_valid     = rxValid;
    ifc.rx_data      = rxData;
    rst_pipe         = pipeRst;
    @(negedge clk);
    obsRdata   = ifc.ibus32_rdata;
    obsTxValid = ifc.tx_valid;
    obsTxData  = ifc.tx_data;
    expTxValid = !mLpbk && (mTx.size() > 0);
    expRxReady = !mLpbk && (mRx.size() < DEPTH);
    checkOutput("rdata", obsRdata, mRsp0);
    checkOutput("tx_valid", 16'(obsTxValid), 16'(expTxValid));
    if (expTxValid) checkOutput("tx_data", obsTxData, mTx[0]);
    checkOutput("rx_ready", 16'(ifc.rx_ready), 16'(expRxReady));
    if (pipeRst) begin
      modelReset();
    end else begin
      ra     = int'(radr);
      wa     = int'(wadr);
      base   = int'(BASE);
      rdHit  = ren && (ra >= base) && (ra <= base + 255);
      rdSt   = rdHit && (ra == base + 255);
      rdDat  = rdHit && !rdSt;
      wrHit  = wen && (wa >= base) && (wa <= base + 255);
      wrSt   = wrHit && (wa == base + 255);
      wrDat  = wrHit && !wrSt;
      txN    = mTx.size();
      rxN    = mRx.size();
      txPop  = expTxValid && txReady;
      rxPush = expRxReady && rxValid;
      move   = mLpbk && (txN > 0) && (rxN < DEPTH);
      moveVal = (txN > 0) ? mTx[0] : 16'h0000;
      setOvf = wrDat && (txN == DEPTH);
      setUdf = rdDat && (rxN == 0);
      newRsp = 16'h0000;
      if (rdSt) newRsp = modelStatus();
      else if (rdDat && rxN > 0) newRsp = mRx.pop_front();
      if (wrSt) begin
        if (wdata[2]) mOvf = 1'b0;
        if (wdata[3]) mUdf = 1'b0;
`ifdef IBUS_STREAM_LOOPBACK_EN
        mLpbk = wdata[4];
`endif
      end
      if (setOvf) mOvf = 1'b1;
      if (setUdf) mUdf = 1'b1;
      if (txPop || move) void'(mTx.pop_front());
      if (wrDat && txN < DEPTH) mTx.push_back(wdata);
      if (rxPush) mRx.push_back(rxData);
      if (move) mRx.push_back(moveVal);
      mRsp0 = mRsp1;
      mRsp1 = newRsp;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n, input logic txReady);
    for (int k = 0; k < n; k++) applyStimulus(0, 16'h0, 0, 16'h0, 16'h0, txReady, 0, 16'h0, 0);
  endtask

  task automatic pipeReset();
    applyStimulus(0, 16'h0, 0, 16'h0, 16'h0, 0, 0, 16'h0, 1);
  endtask

  // Read STATUS and return what appears two cycles later
  task automatic readStatus(output logic [15:0] value);
    applyStimulus(1, BASE + 16'h00FF, 0, 16'h0, 16'h0, 0, 0, 16'h0, 0);
    idle(2, 0);
    value = obsRdata;
  endtask

  function automatic logic [15:0] pickAdr();
    int sel;
    sel = $urandom_range(0, 9);
    if (sel <= 5) return BASE + 16'($urandom_range(0, 254));
    if (sel <= 7) return BASE + 16'h00FF;
    if (sel == 8) return ($urandom_range(0, 1) == 1) ? BASE - 16'd1 : BASE + 16'h0100;
    return 16'($urandom);
  endfunction

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [15:0] rd[6];
    logic [15:0] st;
    int          phase;
    rst_n = 1'b0;
    rst_pipe = 1'b0;
    ifc.ibus_ren = 0; ifc.ibus_radr = 0; ifc.ibus_wen = 0; ifc.ibus_wadr = 0;
    ifc.ibus32_wdata = 0; ifc.tx_ready = 0; ifc.rx_valid = 0; ifc.rx_data = 0;
    modelReset();
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_tx_valid", 16'(ifc.tx_valid), 16'h0000);
    checkOutput("reset_rx_ready", 16'(ifc.rx_ready), 16'h0001);
    checkOutput("reset_rdata", ifc.ibus32_rdata, 16'h0000);
    checkOutput("reset_tx_data", ifc.tx_data, 16'h0000);
    rst_n = 1'b1;

    // Two writes drain in order with tx_ready high
    pipeReset();
    applyStimulus(0, 16'h0, 1, BASE, 16'hA5A5, 1, 0, 16'h0, 0);
    applyStimulus(0, 16'h0, 1, BASE, 16'h5A5A, 1, 0, 16'h0, 0);
    checkOutput("tx_first_valid", 16'(obsTxValid), 16'h0001);
    checkOutput("tx_first_data", obsTxData, 16'hA5A5);
    idle(1, 1);
    checkOutput("tx_second_valid", 16'(obsTxValid), 16'h0001);
    checkOutput("tx_second_data", obsTxData, 16'h5A5A);
    idle(1, 1);
    checkOutput("tx_drained", 16'(obsTxValid), 16'h0000);

    // Back-to-back reads return 1,2,3 two cycles after each strobe
    pipeReset();
    for (int i = 1; i <= 3; i++) applyStimulus(0, 16'h0, 0, 16'h0, 16'h0, 0, 1, 16'(i), 0);
    for (int i = 0; i < 6; i++) begin
      applyStimulus(i < 3, BASE + 16'(i), 0, 16'h0, 16'h0, 0, 0, 16'h0, 0);
      rd[i] = obsRdata;
    end
    checkOutput("b2b_n1", rd[1], 16'h0000);
    checkOutput("b2b_n2", rd[2], 16'h0001);
    checkOutput("b2b_n3", rd[3], 16'h0002);
    checkOutput("b2b_n4", rd[4], 16'h0003);
    checkOutput("b2b_n5", rd[5], 16'h0000);

    // Overflow on the 17th write, then clear TX_OVF through STATUS
    pipeReset();
    for (int i = 0; i < 17; i++) applyStimulus(0, 16'h0, 1, BASE + 16'(i), 16'(i + 100), 0, 0, 16'h0, 0);
    readStatus(st);
    checkOutput("ovf_status", st, 16'h0207);
    applyStimulus(0, 16'h0, 1, BASE + 16'h00FF, 16'h0004, 0, 0, 16'h0, 0);
    readStatus(st);
    checkOutput("ovf_cleared", st, 16'h0203);

    // Underflow read returns zero and sets RX_UDF
    pipeReset();
    applyStimulus(1, BASE, 0, 16'h0, 16'h0, 0, 0, 16'h0, 0);
    idle(2, 0);
    checkOutput("udf_rdata", obsRdata, 16'h0000);
    readStatus(st);
    checkOutput("udf_status", st, 16'h000A);

    // rst_pipe right after a read discards the in-flight response
    pipeReset();
    applyStimulus(0, 16'h0, 0, 16'h0, 16'h0, 0, 1, 16'hBEEF, 0);
    applyStimulus(1, BASE, 0, 16'h0, 16'h0, 0, 0, 16'h0, 0);
    pipeReset();
    idle(1, 0);
    checkOutput("pipe_rst_rdata", obsRdata, 16'h0000);
    readStatus(st);
    checkOutput("pipe_rst_status", st, 16'h0002);

    // LPBK write, then a DATA write either loops back or stays on TX
    pipeReset();
    applyStimulus(0, 16'h0, 1, BASE + 16'h00FF, 16'h0010, 0, 0, 16'h0, 0);
    readStatus(st);
`ifdef IBUS_STREAM_LOOPBACK_EN
    checkOutput("lpbk_status", st, 16'h0012);
    applyStimulus(0, 16'h0, 1, BASE, 16'h1234, 1, 0, 16'h0, 0);
    idle(2, 1);
    checkOutput("lpbk_tx_valid", 16'(obsTxValid), 16'h0000);
    applyStimulus(1, BASE, 0, 16'h0, 16'h0, 1, 0, 16'h0, 0);
    idle(2, 1);
    checkOutput("lpbk_rdata", obsRdata, 16'h1234);
`else
    checkOutput("lpbk_status", st, 16'h0002);
    applyStimulus(0, 16'h0, 1, BASE, 16'h1234, 0, 0, 16'h0, 0);
    idle(2, 0);
    checkOutput("no_lpbk_tx_valid", 16'(obsTxValid), 16'h0001);
    applyStimulus(1, BASE, 0, 16'h0, 16'h0, 0, 0, 16'h0, 0);
    idle(2, 0);
    checkOutput("no_lpbk_rdata", obsRdata, 16'h0000);
`endif

    // Randomized traffic with phases that favour filling or draining each FIFO
    pipeReset();
    for (int c = 0; c < 3000; c++) begin
      phase = (c / 250) % 4;
      applyStimulus($urandom_range(0, 1) == 1, pickAdr(),
                    $urandom_range(0, 1) == 1, pickAdr(), 16'($urandom),
                    (phase == 0) ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 1) == 1),
                    (phase == 1) ? ($urandom_range(0, 7) != 0) : ($urandom_range(0, 1) == 1),
                    16'($urandom),
                    $urandom_range(0, 299) == 0);
    end

    // Asynchronous reset with a read in flight and data in both FIFOs
    pipeReset();
    applyStimulus(0, 16'h0, 1, BASE, 16'h7777, 0, 1, 16'h4444, 0);
    applyStimulus(1, BASE, 0, 16'h0, 16'h0, 0, 0, 16'h0, 0);
    rst_n = 1'b0;
    #2;
    checkOutput("async_tx_valid", 16'(ifc.tx_valid), 16'h0000);
    checkOutput("async_rx_ready", 16'(ifc.rx_ready), 16'h0001);
    checkOutput("async_rdata", ifc.ibus32_rdata, 16'h0000);
    modelReset();
    rst_n = 1'b1;
    idle(3, 0);
    readStatus(st);
    checkOutput("async_status", st, 16'h0002);

    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule
